// File: rtl/mux_41b.sv
// ---------------------------------------------------------------------------
// mux_41b : WIDTH-bit 4-to-1 mux with a combinational result and a
//           registered copy of the result and select code.
// Optional feature macro: MUX41B_HOLD_EN (adds the hold input).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mux_41b #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef MUX41B_HOLD_EN
  input  logic             hold,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_r,
  output logic [1:0]       sel_r
);

  logic load_en;

`ifdef MUX41B_HOLD_EN
  assign load_en = ~hold;
`else
  assign load_en = 1'b1;
`endif

  // An X/Z select propagates as all-X in simulation; synthesis sees don't-care.
  always_comb begin
    case (sel)
      2'd0:    q = a;
      2'd1:    q = b;
      2'd2:    q = c;
      2'd3:    q = d;
      default: q = {WIDTH{1'bx}};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r   <= '0;
      sel_r <= 2'd0;
    end else if (load_en) begin
      q_r   <= q;
      sel_r <= sel;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mux_41b.sv
// ---------------------------------------------------------------------------
// tb_mux_41b : directed self-checking bench for mux_41b (WIDTH 1 and 8).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mux_41b;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] sel;
  logic       a1, b1, c1, d1;
  logic       q1, q1_r;
  logic [1:0] sel1_r;
  logic [7:0] a8, b8, c8, d8;
  logic [7:0] q8, q8_r;
  logic [1:0] sel8_r;
`ifdef MUX41B_HOLD_EN
  logic       hold;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_41b #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef MUX41B_HOLD_EN
    .hold  (hold),
`endif
    .a     (a1),
    .b     (b1),
    .c     (c1),
    .d     (d1),
    .sel   (sel),
    .q     (q1),
    .q_r   (q1_r),
    .sel_r (sel1_r)
  );

  mux_41b #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef MUX41B_HOLD_EN
    .hold  (hold),
`endif
    .a     (a8),
    .b     (b8),
    .c     (c8),
    .d     (d8),
    .sel   (sel),
    .q     (q8),
    .q_r   (q8_r),
    .sel_r (sel8_r)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] sel_seq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic       q1_exp  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0] q8_exp  [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

  initial begin
    rst_n = 1'b0;
`ifdef MUX41B_HOLD_EN
    hold  = 1'b0;
`endif
    a1 = 1'b1; b1 = 1'b0; c1 = 1'b1; d1 = 1'b0;
    a8 = 8'h11; b8 = 8'h22; c8 = 8'h33; d8 = 8'h44;
    sel = 2'd3;
    #2;
    check("reset_q_r", q1_r, 0);
    check("reset_sel_r", sel1_r, 0);
    check("reset_q8_r", q8_r, 0);
    check("q_during_reset", q1, 0);
    check("q8_during_reset", q8, 8'h44);
    edge_settle();
    check("reset_held_q8_r", q8_r, 0);

    @(negedge clk);
    rst_n = 1'b1;

    // Sweep: combinational result right away, registered copy after the edge.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      sel = sel_seq[i];
      #1;
      check("sweep_q", q1, q1_exp[i]);
      check("sweep_q8", q8, q8_exp[i]);
      check("sweep_q_r_before_edge", q1_r, (i == 0) ? 1'b0 : q1_exp[i-1]);
      edge_settle();
      check("sweep_q_r", q1_r, q1_exp[i]);
      check("sweep_q8_r", q8_r, q8_exp[i]);
      check("sweep_sel_r", sel1_r, sel_seq[i]);
    end

    // Asynchronous reset between edges.
    @(negedge clk);
    sel = 2'd2;
    edge_settle();
    check("pre_reset_q_r", q1_r, 1);
    check("pre_reset_sel_r", sel1_r, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_q_r", q1_r, 0);
    check("async_sel_r", sel1_r, 0);
    check("async_q8_r", q8_r, 0);
    check("async_q", q1, 1);
    check("async_q8", q8, 8'h33);
    @(negedge clk);
    rst_n = 1'b1;

    // Data-only change with sel held at 2.
    edge_settle();
    check("data_pre_q_r", q1_r, 1);
    @(negedge clk);
    c1 = 1'b0;
    #1;
    check("data_q", q1, 0);
    check("data_q_r_hold", q1_r, 1);
    edge_settle();
    check("data_q_r", q1_r, 0);

    // sel and data change together.
    @(negedge clk);
    sel = 2'd3;
    d1  = 1'b1;
    d8  = 8'hA5;
    edge_settle();
    check("both_q_r", q1_r, 1);
    check("both_q8_r", q8_r, 8'hA5);
    check("both_sel_r", sel1_r, 3);

`ifdef MUX41B_HOLD_EN
    @(negedge clk);
    sel = 2'd0;
    edge_settle();
    check("hold_pre_q_r", q1_r, 1);
    check("hold_pre_sel_r", sel1_r, 0);
    @(negedge clk);
    hold = 1'b1;
    sel  = 2'd1;
    #1;
    check("hold_q", q1, 0);
    edge_settle();
    edge_settle();
    check("hold_q_r", q1_r, 1);
    check("hold_sel_r", sel1_r, 0);
    check("hold_q8_r", q8_r, 8'h11);
    @(negedge clk);
    hold = 1'b0;
    edge_settle();
    check("unhold_q_r", q1_r, 0);
    check("unhold_sel_r", sel1_r, 1);
    check("unhold_q8_r", q8_r, 8'h22);
    @(negedge clk);
    hold  = 1'b1;
    rst_n = 1'b0;
    #1;
    check("hold_reset_sel_r", sel1_r, 0);
    check("hold_reset_q8_r", q8_r, 0);
    @(negedge clk);
    rst_n = 1'b1;
    hold  = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mux_41b.md
# mux_41b

Parameterised 4-to-1 multiplexer with a combinational output and a registered copy of the selection result. It selects one of four equal-width data inputs by a 2-bit select and presents the result immediately on `q` and one clock later on `q_r`. It is a leaf datapath block used wherever a small steering mux feeds either combinational logic or a pipeline stage.

## Interface

Reset is asynchronous and active-low; the block has exactly one clock.

**Parameters**

- `WIDTH`, default 1: bit width of each data input and of both outputs; legal range is 1 to 64.

**Ports**

- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `a` input WIDTH: data input, selected when `sel` = 0.
- `b` input WIDTH: data input, selected when `sel` = 1.
- `c` input WIDTH: data input, selected when `sel` = 2.
- `d` input WIDTH: data input, selected when `sel` = 3.
- `sel` input 2: select code.
- `q` output WIDTH: combinational mux result.
- `q_r` output WIDTH: registered mux result.
- `sel_r` output 2: registered copy of `sel`, aligned with `q_r`.
- `hold` input 1: freeze control for the registers; this port exists only when `MUX41B_HOLD_EN` is defined.

## Operation

- `q` follows `sel` directly:
  - `sel` = 0 gives `q` = `a`.
  - `sel` = 1 gives `q` = `b`.
  - `sel` = 2 gives `q` = `c`.
  - `sel` = 3 gives `q` = `d`.
- `q` has no dependence on `clk` or `rst_n`, and it is valid even while reset is asserted.
- All four `sel` codes are decoded; there is no illegal code.
- If `sel` contains X or Z, the behaviour is simulation-only: `q` goes to all-X. Synthesis treats those bits as don't-care.
- On each rising `clk` edge with `rst_n` high, the block loads `q_r` with the current `q` and `sel_r` with `sel`.
- Data passes through bit-for-bit. There is no arithmetic, sign extension or width conversion.

## Timing

- `q` has zero cycles of latency. It is purely combinational from `a`, `b`, `c`, `d` and `sel`.
- `q_r` and `sel_r` have one cycle of latency. Their values after edge N equal `q` and `sel` just before edge N.
- Reset values: `q_r` = 0 and `sel_r` = 0.
- Reset assertion clears `q_r` and `sel_r` immediately, without waiting for a clock edge.
- Reset deassertion is synchronised externally. The first load happens on the first rising edge after `rst_n` goes high.
- Reset asserted mid-stream: registered outputs go to 0 at once, while `q` keeps tracking its inputs.
- If `sel` and a data input change in the same cycle, `q_r` captures the new combination at the next edge.

## Configuration

- Macro `MUX41B_HOLD_EN`.
- When defined:
  - The `hold` input port is present.
  - When `hold` = 1 at a rising edge, `q_r` and `sel_r` keep their values.
  - When `hold` = 0, they load normally.
  - Reset overrides `hold`.
  - `q` is unaffected by `hold`.
- When undefined, the `hold` port is absent and the registers load every cycle.

## Test plan

- Combinational sweep, `WIDTH` = 1: set `a`=1, `b`=0, `c`=1, `d`=0, then step `sel` through 0, 1, 2, 3, 0 at 10 ns intervals. Required `q` sequence: 1, 0, 1, 0, 1.
- Register latency: apply the same sweep with one `sel` step per clock. `q_r` must repeat the `q` sequence one cycle later, and `sel_r` must repeat 0, 1, 2, 3 one cycle later.
- Asynchronous reset: with `q_r`=1, drive `rst_n` low between clock edges. `q_r` and `sel_r` must go to 0 immediately. `q` must still equal the selected input.
- Wide data, `WIDTH`=8: set `a`=0x11, `b`=0x22, `c`=0x33, `d`=0x44 and sweep `sel` from 0 to 3. Required `q` sequence: 0x11, 0x22, 0x33, 0x44.
- Data-only change: hold `sel`=2 and toggle `c` from 1 to 0. `q` must change immediately, and `q_r` must change at the next edge.
- `MUX41B_HOLD_EN` defined: with `hold`=1, change `sel` from 0 to 1 across two edges. `q_r` and `sel_r` must stay frozen. After `hold`=0, they must update at the next edge.
